uart_tx: RTL



---
 rtl/uart_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 parity bit, stop bit(s).
// Define UART_TX_TWO_STOP_EN to stretch the stop level to two bit periods.
module uart_tx #(
    parameter int unsigned BIT_TICKS  = 5208,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       finish
);

    localparam int unsigned TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state, state_d;
    logic [TW-1:0]   tick, tick_d;
    logic [2:0]      bit_cnt, bit_cnt_d;
    logic [7:0]      shift, shift_d;
    logic            parity, parity_d;
    logic            tx_d, busy_d, finish_d;
    logic            tick_end;
`ifdef UART_TX_TWO_STOP_EN
    logic            stop_cnt, stop_cnt_d;
`endif

    assign tick_end = (tick == TICK_LAST);

    // State and output registers; tx/busy/finish follow the next state directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tick     <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            parity   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            finish   <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            tick     <= tick_d;
            bit_cnt  <= bit_cnt_d;
            shift    <= shift_d;
            parity   <= parity_d;
            tx       <= tx_d;
            busy     <= busy_d;
            finish   <= finish_d;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt <= stop_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state;
        tick_d    = tick_end ? '0 : tick + TW'(1);
        bit_cnt_d = bit_cnt;
        shift_d   = shift;
        parity_d  = parity;
        finish_d  = 1'b0;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt;
`endif

        case (state)
            IDLE: begin
                tick_d = '0;
                if (start) begin
                    state_d   = START;
                    shift_d   = data_in;
                    parity_d  = (^data_in) ^ (PARITY_ODD != 0);
                    bit_cnt_d = '0;
`ifdef UART_TX_TWO_STOP_EN
                    stop_cnt_d = 1'b0;
`endif
                end
            end
            START: begin
                if (tick_end) state_d = DATA;
            end
            DATA: begin
                if (tick_end) begin
                    shift_d   = {1'b0, shift[7:1]};
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_d = PARITY;
                end
            end
            PARITY: begin
                if (tick_end) state_d = STOP;
            end
            STOP: begin
                if (tick_end) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (!stop_cnt) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        state_d  = IDLE;
                        finish_d = 1'b1;
                    end
`else
                    state_d  = IDLE;
                    finish_d = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is decided by the state being entered so tx stays registered.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule
